lane_object_tracker: RTL and testbench

//  Far end of the game sequencer's release interface. Consumes RELEASE_BARRIER/RELEASE_COIN,

---
 rtl/lane_object_tracker_if.sv | 13 +
 rtl/lane_object_tracker.sv | 158 +++++++++++++++
 tb/tb_lane_object_tracker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lane_object_tracker_if.sv
// Release/hit interface between the game sequencer (master) and the lane object tracker (slave).
interface lane_object_tracker_if;
    logic [1:0] RELEASE_BARRIER;
    logic [1:0] RELEASE_COIN;
    logic       PENGUIN_HIT;
    logic       COIN_HIT;
    logic       ZERO_LIVES;

    modport master (output RELEASE_BARRIER, RELEASE_COIN,
                    input  PENGUIN_HIT, COIN_HIT, ZERO_LIVES);
    modport slave  (input  RELEASE_BARRIER, RELEASE_COIN,
                    output PENGUIN_HIT, COIN_HIT, ZERO_LIVES);
endinterface

// File: rtl/lane_object_tracker.sv
// Scrolls one barrier and one coin down their lanes per frame and scores them against the penguin.
// Optional build macro DEBUG_INVINCIBLE_EN: barrier hits still pulse but never cost a life.
module lane_object_fsm #(
    parameter int SPAWN_Y   = 0,
    parameter int PENGUIN_Y = 400,
    parameter int HIT_WIN   = 16,
    parameter int SPEED     = 4,
    parameter int SCREEN_H  = 480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       tick_i,
    input  logic       run_i,
    input  logic       kill_i,
    input  logic [1:0] rel_i,
    input  logic [1:0] lane_i,
    input  logic       block_i,
    output logic       hit_o,
    output logic       hit_evt_o,
    output logic [9:0] y_o,
    output logic       vis_o
);
    typedef enum logic [1:0] {IDLE, FALL, HIT, WAIT_CLR} state_e;

    localparam logic [9:0]  WIN_LO = 10'(PENGUIN_Y - HIT_WIN);
    localparam logic [9:0]  WIN_HI = 10'(PENGUIN_Y + HIT_WIN);
    localparam logic [10:0] SCR_H  = 11'(SCREEN_H);

    state_e      state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  l_q, l_d;
    logic [10:0] y_adv;
    logic        step, in_win;

    assign step   = tick_i && run_i;
    assign y_adv  = {1'b0, y_q} + 11'(SPEED);
    assign in_win = (y_q >= WIN_LO) && (y_q <= WIN_HI);

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        l_d       = l_q;
        hit_evt_o = 1'b0;
        case (state_q)
            IDLE: if (step && !kill_i && rel_i != 2'b00) begin
                state_d = FALL;
                y_d     = 10'(SPAWN_Y);
                l_d     = rel_i;
            end
            FALL: begin
                if (kill_i) state_d = IDLE;
                else if (step) begin
                    if (rel_i == 2'b00) state_d = IDLE;
                    else if (rel_i != l_q) begin
                        y_d = 10'(SPAWN_Y);
                        l_d = rel_i;
                    end else if (in_win && l_q == lane_i && !block_i) begin
                        state_d   = HIT;
                        hit_evt_o = 1'b1;
                    end else begin
                        y_d = (y_adv >= SCR_H) ? SCR_H[9:0] : y_adv[9:0];
                        if (y_adv >= SCR_H) state_d = WAIT_CLR;
                    end
                end
            end
            // The pulse ends on the next tick even while paused.
            HIT:      if (tick_i) state_d = WAIT_CLR;
            WAIT_CLR: if (kill_i || rel_i == 2'b00) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            y_q     <= 10'(SPAWN_Y);
            l_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            l_q     <= l_d;
        end
    end

    assign hit_o = (state_q == HIT);
    assign vis_o = (state_q == FALL);
    assign y_o   = y_q;
endmodule

module lane_object_tracker #(
    parameter int SPAWN_Y     = 0,
    parameter int PENGUIN_Y   = 400,
    parameter int HIT_WIN     = 16,
    parameter int SPEED       = 4,
    parameter int SCREEN_H    = 480,
    parameter int START_LIVES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_tick,
    input  logic                 GAME_SWITCH,
    input  logic [1:0]           PENGUIN_LANE,
    input  logic                 PENGUIN_JUMP,
    lane_object_tracker_if.slave rel_if,
    output logic [1:0]           LIVES,
    output logic [7:0]           COIN_COUNT,
    output logic [9:0]           BARRIER_Y,
    output logic                 BARRIER_VIS,
    output logic [9:0]           COIN_Y,
    output logic                 COIN_VIS
);
    logic [1:0] lives_q, lives_d;
    logic [7:0] coins_q, coins_d;
    logic       zero_q;
    logic       b_hit, b_evt, c_hit, c_evt;

    lane_object_fsm #(.SPAWN_Y(SPAWN_Y), .PENGUIN_Y(PENGUIN_Y), .HIT_WIN(HIT_WIN),
                      .SPEED(SPEED), .SCREEN_H(SCREEN_H)) u_barrier (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .tick_i(i_frame_tick), .run_i(GAME_SWITCH),
        .kill_i(zero_q), .rel_i(rel_if.RELEASE_BARRIER), .lane_i(PENGUIN_LANE),
        .block_i(PENGUIN_JUMP), .hit_o(b_hit), .hit_evt_o(b_evt),
        .y_o(BARRIER_Y), .vis_o(BARRIER_VIS));

    lane_object_fsm #(.SPAWN_Y(SPAWN_Y), .PENGUIN_Y(PENGUIN_Y), .HIT_WIN(HIT_WIN),
                      .SPEED(SPEED), .SCREEN_H(SCREEN_H)) u_coin (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .tick_i(i_frame_tick), .run_i(GAME_SWITCH),
        .kill_i(zero_q), .rel_i(rel_if.RELEASE_COIN), .lane_i(PENGUIN_LANE),
        .block_i(1'b0), .hit_o(c_hit), .hit_evt_o(c_evt),
        .y_o(COIN_Y), .vis_o(COIN_VIS));

`ifdef DEBUG_INVINCIBLE_EN
    logic unused_b_evt;
    assign unused_b_evt = b_evt;
    assign lives_d      = lives_q;
`else
    assign lives_d = (b_evt && lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
`endif
    assign coins_d = (c_evt && coins_q != 8'hFF) ? coins_q + 8'd1 : coins_q;

    // ZERO_LIVES tracks the lives value being written, so it rises on the fatal hit's edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lives_q <= 2'(START_LIVES);
            coins_q <= 8'd0;
            zero_q  <= 1'b0;
        end else begin
            lives_q <= lives_d;
            coins_q <= coins_d;
            zero_q  <= (lives_d == 2'd0);
        end
    end

    assign rel_if.PENGUIN_HIT = b_hit;
    assign rel_if.COIN_HIT    = c_hit;
    assign rel_if.ZERO_LIVES  = zero_q;
    assign LIVES              = lives_q;
    assign COIN_COUNT         = coins_q;
endmodule

// File: tb/tb_lane_object_tracker.sv
// Scoreboard bench for lane_object_tracker: expected hit records queued per scenario, checked on pulses.
module tb_lane_object_tracker;
    localparam int GAP   = 4;
    localparam int FRAME = GAP + 1;

    logic       i_clk = 0, i_rst_n = 0, i_frame_tick = 0, GAME_SWITCH = 1;
    logic [1:0] PENGUIN_LANE = 0;
    logic       PENGUIN_JUMP = 0;
    logic [1:0] LIVES;
    logic [7:0] COIN_COUNT;
    logic [9:0] BARRIER_Y, COIN_Y;
    logic       BARRIER_VIS, COIN_VIS;

    lane_object_tracker_if rif ();

    lane_object_tracker dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick),
        .GAME_SWITCH(GAME_SWITCH), .PENGUIN_LANE(PENGUIN_LANE), .PENGUIN_JUMP(PENGUIN_JUMP),
        .rel_if(rif), .LIVES(LIVES), .COIN_COUNT(COIN_COUNT), .BARRIER_Y(BARRIER_Y),
        .BARRIER_VIS(BARRIER_VIS), .COIN_Y(COIN_Y), .COIN_VIS(COIN_VIS));

    always #5 i_clk = ~i_clk;

    typedef struct { int y; int v; int both; } exp_t;
    exp_t bq[$], cq[$];
    exp_t eb, ec;
    int   errs = 0, nchk = 0;
    int   bw = 0, cw = 0;
    logic pb = 0, pc = 0;
    int   lives_m = 3;

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int after_hit(input int l);
`ifdef DEBUG_INVINCIBLE_EN
        return l;
`else
        return (l > 0) ? l - 1 : 0;
`endif
    endfunction

    task automatic frame(input int n);
        repeat (n) begin
            i_frame_tick = 1;
            @(posedge i_clk); #1;
            i_frame_tick = 0;
            repeat (GAP) @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clk1();
        @(posedge i_clk); #1;
    endtask

    // Monitor: each rising hit pulse pops its expected record; each pulse must last one frame.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            bw = 0; cw = 0; pb = 0; pc = 0;
        end else begin
            if (rif.PENGUIN_HIT && !pb) begin
                chk("bhit_expected", int'(bq.size() > 0), 1);
                if (bq.size() > 0) begin
                    eb = bq.pop_front();
                    chk("bhit_y", BARRIER_Y, eb.y);
                    chk("bhit_lives", LIVES, eb.v);
                    chk("bhit_vis", BARRIER_VIS, 0);
                    chk("bhit_coin_same", rif.COIN_HIT, eb.both);
                end
            end
            if (rif.COIN_HIT && !pc) begin
                chk("chit_expected", int'(cq.size() > 0), 1);
                if (cq.size() > 0) begin
                    ec = cq.pop_front();
                    chk("chit_y", COIN_Y, ec.y);
                    chk("chit_count", COIN_COUNT, ec.v);
                    chk("chit_vis", COIN_VIS, 0);
                    chk("chit_bar_same", rif.PENGUIN_HIT, ec.both);
                end
            end
            if (rif.PENGUIN_HIT) bw++;
            else if (pb) begin chk("bhit_width", bw, FRAME); bw = 0; end
            if (rif.COIN_HIT) cw++;
            else if (pc) begin chk("chit_width", cw, FRAME); cw = 0; end
            pb = rif.PENGUIN_HIT;
            pc = rif.COIN_HIT;
        end
    end

    initial begin
        rif.RELEASE_BARRIER = 0;
        rif.RELEASE_COIN    = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_lives", LIVES, 3);
        chk("rst_zero", rif.ZERO_LIVES, 0);
        chk("rst_coins", COIN_COUNT, 0);
        chk("rst_by", BARRIER_Y, 0);
        chk("rst_bvis", BARRIER_VIS, 0);
        chk("rst_phit", rif.PENGUIN_HIT, 0);
        i_rst_n = 1;
        clk1();

        // Barrier in the mid lane hits a grounded penguin at the first window line.
        PENGUIN_LANE = 2'b10; PENGUIN_JUMP = 0; rif.RELEASE_BARRIER = 2'b10;
        lives_m = after_hit(lives_m);
        bq.push_back('{384, lives_m, 0});
        frame(100);
        chk("t1_vis", BARRIER_VIS, 0);
        chk("t1_lives", LIVES, lives_m);
        rif.RELEASE_BARRIER = 0; clk1();

        // Jumping penguin: barrier passes under and runs off-screen.
        PENGUIN_JUMP = 1; rif.RELEASE_BARRIER = 2'b10;
        frame(130);
        chk("t2_y", BARRIER_Y, 480);
        chk("t2_vis", BARRIER_VIS, 0);
        chk("t2_lives", LIVES, lives_m);
        rif.RELEASE_BARRIER = 0; clk1();
        PENGUIN_JUMP = 0;

        // Coin collected once; holding the release must not respawn it.
        PENGUIN_LANE = 2'b11; rif.RELEASE_COIN = 2'b11;
        cq.push_back('{384, 1, 0});
        frame(100);
        frame(30);
        chk("t3_count", COIN_COUNT, 1);
        chk("t3_vis_held", COIN_VIS, 0);
        rif.RELEASE_COIN = 0; clk1();
        rif.RELEASE_COIN = 2'b01;
        frame(1);
        chk("t3_respawn_y", COIN_Y, 0);
        chk("t3_respawn_vis", COIN_VIS, 1);
        frame(1);
        chk("t3_step_y", COIN_Y, 4);
        rif.RELEASE_COIN = 0;
        frame(1);
        chk("t3_idle_vis", COIN_VIS, 0);

        // Coin and barrier in one lane reach the window together.
        PENGUIN_LANE = 2'b01; rif.RELEASE_BARRIER = 2'b01; rif.RELEASE_COIN = 2'b01;
        lives_m = after_hit(lives_m);
        bq.push_back('{384, lives_m, 1});
        cq.push_back('{384, 2, 1});
        frame(100);
        chk("t5_lives", LIVES, lives_m);
        chk("t5_count", COIN_COUNT, 2);
        rif.RELEASE_BARRIER = 0; rif.RELEASE_COIN = 0; clk1();

        // Lane change mid-fall re-arms at the top; pause freezes the object.
        PENGUIN_LANE = 2'b10; rif.RELEASE_BARRIER = 2'b01;
        frame(10);
        chk("t6_y_fall", BARRIER_Y, 36);
        rif.RELEASE_BARRIER = 2'b11;
        frame(1);
        chk("t6_rearm_y", BARRIER_Y, 0);
        chk("t6_rearm_vis", BARRIER_VIS, 1);
        frame(1);
        chk("t6_y4", BARRIER_Y, 4);
        GAME_SWITCH = 0;
        frame(5);
        chk("pause_y", BARRIER_Y, 4);
        chk("pause_vis", BARRIER_VIS, 1);
        GAME_SWITCH = 1;

        // Final barrier hit in lane 11 (already falling at Y=4).
        PENGUIN_LANE = 2'b11;
        lives_m = after_hit(lives_m);
        bq.push_back('{384, lives_m, 0});
        frame(100);
        chk("t4_lives", LIVES, lives_m);
        chk("t4_zero", rif.ZERO_LIVES, int'(lives_m == 0));
`ifndef DEBUG_INVINCIBLE_EN
        rif.RELEASE_BARRIER = 0; clk1();
        PENGUIN_LANE = 2'b10; rif.RELEASE_BARRIER = 2'b10; rif.RELEASE_COIN = 2'b10;
        frame(110);
        chk("dead_bvis", BARRIER_VIS, 0);
        chk("dead_cvis", COIN_VIS, 0);
        chk("dead_lives", LIVES, 0);
        chk("dead_count", COIN_COUNT, 2);
        chk("dead_zero", rif.ZERO_LIVES, 1);
`endif
        rif.RELEASE_BARRIER = 0; rif.RELEASE_COIN = 0;

        // Fresh game, then async reset mid-fall.
        i_rst_n = 0; clk1(); i_rst_n = 1; clk1();
        PENGUIN_LANE = 2'b01; rif.RELEASE_COIN = 2'b10;
        frame(10);
        chk("rst2_pre_y", COIN_Y, 36);
        chk("rst2_pre_vis", COIN_VIS, 1);
        @(negedge i_clk); #2;
        i_rst_n = 0;
        #1;
        chk("rst2_cy", COIN_Y, 0);
        chk("rst2_cvis", COIN_VIS, 0);
        chk("rst2_lives", LIVES, 3);
        chk("rst2_count", COIN_COUNT, 0);
        chk("rst2_zero", rif.ZERO_LIVES, 0);
        rif.RELEASE_COIN = 0;
        clk1();

        chk("bq_drained", bq.size(), 0);
        chk("cq_drained", cq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
